// File: rtl/shift_reg_univ.sv
// shift_reg_univ: WIDTH-bit universal shift register with hold, shift right,
// shift left and parallel load, a per-bit output inversion mask, and a
// burst sequencer that shifts a programmed number of places on its own and
// then pulses done.
//
// Burst handshake: burst_start is sampled only while the sequencer is idle
// (busy=0) and ce=1. A non-zero burst_len is accepted on that edge. busy is
// high for exactly burst_len enabled shift cycles, and done pulses for one
// cycle after the last shift. A zero burst_len skips busy and pulses done on
// the next cycle. A new request is accepted in the same cycle that done is
// high, because the sequencer is already back in idle.
module shift_reg_univ #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b0}},
  parameter int               LEN_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic             burst_start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             burst_dir,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sr_out,
  output logic             sl_out,
  output logic             busy,
  output logic             done,
  output logic             state_dbg
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] r, r_next;
  logic [LEN_W-1:0] cnt, cnt_next;
  logic             dir, dir_next;
  logic             done_next;

  // Both one-place shift results; the mode decode and the burst path share them.
  logic [WIDTH-1:0] r_shr;
  logic [WIDTH-1:0] r_shl;

  assign r_shr = {sr_in, r[WIDTH-1:1]};
  assign r_shl = {r[WIDTH-2:0], sl_in};

  // The register stores raw data. Polarity is applied only on the way out.
  assign q         = r ^ INV_MASK;
  assign qn        = ~(r ^ INV_MASK);
  assign sr_out    = r[0];
  assign sl_out    = r[WIDTH-1];
  assign busy      = (state == S_SHIFT);
  assign state_dbg = state;

  // Next-state logic. With ce low everything holds, and done drops because its default is 0.
  always_comb begin
    r_next     = r;
    state_next = state;
    cnt_next   = cnt;
    dir_next   = dir;
    done_next  = 1'b0;

    if (ce) begin
      unique case (state)
        S_IDLE: begin
          if (burst_start) begin
            // A burst request takes priority over mode, and r holds on the accept edge.
            if (burst_len != CNT_ZERO) begin
              cnt_next   = burst_len;
              dir_next   = burst_dir;
              state_next = S_SHIFT;
            end else begin
              done_next = 1'b1;
            end
          end else begin
            unique case (mode)
              MODE_HOLD:  r_next = r;
              MODE_RIGHT: r_next = r_shr;
              MODE_LEFT:  r_next = r_shl;
              MODE_LOAD:  r_next = d;
              default:    r_next = r;
            endcase
          end
        end

        S_SHIFT: begin
          // mode and burst_start are ignored until the burst runs out.
          r_next   = dir ? r_shl : r_shr;
          cnt_next = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end

        default: begin
          state_next = S_IDLE;
          cnt_next   = CNT_ZERO;
        end
      endcase
    end
  end

  // State register. rst wins over ce and aborts any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r     <= {WIDTH{1'b0}};
      state <= S_IDLE;
      cnt   <= CNT_ZERO;
      dir   <= 1'b0;
      done  <= 1'b0;
    end else begin
      r     <= r_next;
      state <= state_next;
      cnt   <= cnt_next;
      dir   <= dir_next;
      done  <= done_next;
    end
  end

endmodule
